// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared MIPS16 opcode, field and fetch-state definitions
//
// Purpose: constants and types shared between the fetch stage and the main
// decoder. No ports.
package mips16_pkg;

    localparam logic [2:0] OP_PASS   = 3'b000;
    localparam logic [2:0] OP_RTYPE  = 3'b001;
    localparam logic [2:0] OP_ADDI   = 3'b010;
    localparam logic [2:0] OP_SUBI   = 3'b011;
    localparam logic [2:0] OP_MEM    = 3'b100;
    localparam logic [2:0] OP_BR     = 3'b101;
    localparam logic [2:0] OP_JAL_JR = 3'b110;
    localparam logic [2:0] OP_J      = 3'b111;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int SEL_BIT = 12;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS16 fetch stage: PC, imem req/ack, instruction register
//
// Purpose: owns the PC, fetches one word per request from instruction memory,
// holds it in the IR with its PC and hands it to the decoder.
// Optional build macro: IF_PERF_EN adds a saturating discarded-fetch counter.
//
// Ports:
//   clk, reset_n            core clock (rising edge), async active-low reset
//   imem_req/imem_addr      fetch request and word address (held until ack)
//   imem_ack/imem_rdata     one-cycle ack with the fetched word
//   stall                   downstream not accepting; IR holds
//   redirect/redirect_pc    one-cycle PC reload from branch/jump resolution
//   if_valid/if_instr       IR live flag and contents
//   if_pc/if_pc_plus1       address of IR and its successor (JAL link)
//   op/select               decoder fields sliced from the IR
//   perf_discard_cnt        (IF_PERF_EN only) count of discarded fetches
module instr_fetch
    import mips16_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [PC_W-1:0]    if_pc_plus1,
    output logic [2:0]         op,
    output logic               select
`ifdef IF_PERF_EN
    ,
    output logic [15:0]        perf_discard_cnt
`endif
);

    fetch_state_t    state, state_nx;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] drain_addr;
    logic            req_active;
    logic            ack;
    logic            take;
    logic            consume;

    assign consume = if_valid & ~stall;
    assign ack     = imem_req & imem_ack;
    // Only an ack in REQ with no redirect delivers an instruction; every other
    // ack belongs to a fetch made stale by a redirect.
    assign take    = ack & ~redirect & (state == FS_REQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            FS_IDLE: begin
                state_nx = FS_REQ;
            end
            FS_REQ: begin
                // A new request may only start when the IR has room for its
                // data; once started it stays up until acked.
                imem_req = req_active | ~if_valid | ~stall;
                if (redirect && imem_req && !imem_ack) begin
                    state_nx = FS_DRAIN;
                end
            end
            FS_DRAIN: begin
                // pc already holds the redirect target; the stale request
                // keeps its original address until memory acks it.
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ack) begin
                    state_nx = FS_REQ;
                end
            end
            default: begin
                state_nx = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            drain_addr  <= '0;
            req_active  <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
        end else begin
            if (ack) begin
                req_active <= 1'b0;
            end else if (imem_req) begin
                req_active <= 1'b1;
            end

            if (state == FS_REQ && state_nx == FS_DRAIN) begin
                drain_addr <= pc;
            end

            if (redirect) begin
                pc       <= redirect_pc;
                if_valid <= 1'b0;
            end else if (take) begin
                if_instr    <= imem_rdata;
                if_pc       <= pc;
                if_pc_plus1 <= pc + 1'b1;
                if_valid    <= 1'b1;
                pc          <= pc + 1'b1;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
        end
    end

    assign op     = if_instr[OP_HI:OP_LO];
    assign select = if_instr[SEL_BIT];

`ifdef IF_PERF_EN
    logic discard;
    assign discard = ack & (redirect | (state == FS_DRAIN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_discard_cnt <= '0;
        end else if (discard && perf_discard_cnt != 16'hFFFF) begin
            perf_discard_cnt <= perf_discard_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic [2:0]  op;
    logic        select;
`ifdef IF_PERF_EN
    logic [15:0] perf_discard_cnt;
`endif

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int ack_delay = 1;

    // Scoreboard of {pc, instr} expected on if_* in order.
    logic [31:0] sb_q[$];
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_drain_addr = 16'h0000;
    bit          m_out = 0;
    bit          m_drain = 0;
    bit          m_idle = 1;
    int          cnt = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus1 (if_pc_plus1),
        .op          (op),
        .select      (select)
`ifdef IF_PERF_EN
        ,
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h2401;
            16'h0001: return 16'h4802;
            default:  return {a[7:0] ^ 8'hC3, a[15:8] ^ a[7:0]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_pc(input string tag, input logic [15:0] pc);
        int n = 0;
        while (!(if_valid === 1'b1 && if_pc === pc) && n < 60) begin
            tick();
            n++;
        end
        check(tag, {15'd0, if_valid, if_pc}, {15'd0, 1'b1, pc});
    endtask

    task automatic wait_req_addr(input string tag, input logic [15:0] addr);
        int n = 0;
        while (!(imem_req === 1'b1 && imem_addr === addr) && n < 60) begin
            tick();
            n++;
        end
        check(tag, {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, addr});
    endtask

    // Stall until the IR is full and no fetch is outstanding, then redirect,
    // so the redirect only flushes and discards nothing. Leaves stall high.
    task automatic quiet_redirect(input logic [15:0] target);
        stall = 1'b1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
        check("flush_under_stall", {31'd0, if_valid}, 32'd0);
    endtask

    // Reference model, memory responder and scoreboard, all at negedge.
    always @(negedge clk) begin
        logic        exp_req;
        logic        ack_now;
        logic [31:0] e;
        if (!reset_n) begin
            sb_q.delete();
            m_out    = 0;
            m_drain  = 0;
            m_idle   = 1;
            cnt      = 0;
            imem_ack = 1'b0;
            m_pc     = 16'h0000;
        end else begin
            exp_req = m_idle ? 1'b0 : (m_drain | m_out | (sb_q.size() == 0) | ~stall);
            check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
            check("if_valid", {31'd0, if_valid}, {31'd0, sb_q.size() != 0});
            if (exp_req) begin
                check("imem_addr", {16'd0, imem_addr}, {16'd0, m_drain ? m_drain_addr : m_pc});
            end
            if (sb_q.size() != 0 && !stall) begin
                e = sb_q.pop_front();
                check("if_pc", {16'd0, if_pc}, {16'd0, e[31:16]});
                check("if_instr", {16'd0, if_instr}, {16'd0, e[15:0]});
                check("if_pc_plus1", {16'd0, if_pc_plus1}, {16'd0, e[31:16] + 16'd1});
                check("op", {29'd0, op}, {29'd0, e[15:13]});
                check("select", {31'd0, select}, {31'd0, e[12]});
            end
            if (redirect) begin
                sb_q.delete();
            end

            ack_now    = imem_req && (cnt >= ack_delay);
            imem_ack   = ack_now;
            imem_rdata = ack_now ? mem(imem_addr) : 16'hBAD0;
            if (imem_req && !ack_now) cnt++;
            else cnt = 0;

            if (ack_now && (redirect || m_drain)) begin
                m_drain = 0;
                m_out   = 0;
            end else if (ack_now) begin
                sb_q.push_back({m_pc, mem(m_pc)});
                m_pc  = m_pc + 16'd1;
                m_out = 0;
            end else if (imem_req) begin
                if (redirect && !m_drain) begin
                    m_drain      = 1;
                    m_drain_addr = m_pc;
                end
                m_out = 1;
            end
            if (redirect) m_pc = redirect_pc;
            m_idle = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        ack_delay   = 1;
        #3;
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_instr", {16'd0, if_instr}, 32'd0);
        check("rst_if_pc", {16'd0, if_pc}, 32'd0);
        check("rst_if_pc_plus1", {16'd0, if_pc_plus1}, 32'd0);
        check("rst_op_sel", {28'd0, op, select}, 32'd0);
`ifdef IF_PERF_EN
        check("rst_perf", {16'd0, perf_discard_cnt}, 32'd0);
`endif
        tick();
        tick();
        reset_n = 1'b1;

        // Basic in-order fetch, ack one cycle after each request.
        wait_valid_pc("first_valid", 16'h0000);
        check("first_instr", {16'd0, if_instr}, 32'h2401);
        check("first_op", {29'd0, op}, 32'd1);
        check("first_select", {31'd0, select}, 32'd0);
        tick();
        wait_valid_pc("second_valid", 16'h0001);
        check("second_instr", {16'd0, if_instr}, 32'h4802);
        check("second_op", {29'd0, op}, 32'd2);

        // Stall while the fetch of 5 is in flight; IR fills then holds.
        wait_valid_pc("reach_pc4", 16'h0004);
        tick();
        stall = 1'b1;
        tick();
        check("stall_pc", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0005});
        check("stall_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("stall_pc2", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'h0005});
        check("stall_instr", {16'd0, if_instr}, {16'd0, mem(16'h0005)});
        tick();
        stall = 1'b0;

        // Redirect with a request outstanding: drain the stale fetch.
        ack_delay = 2;
        wait_req_addr("req_at_9", 16'h0009);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("drain_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0009});
        check("drain_flush", {31'd0, if_valid}, 32'd0);
        tick();
        tick();
        check("after_drain", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0040});
        check("after_drain_valid", {31'd0, if_valid}, 32'd0);
`ifdef IF_PERF_EN
        check("perf_one", {16'd0, perf_discard_cnt}, 32'd1);
`endif
        wait_valid_pc("target_40", 16'h0040);
        check("target_40_instr", {16'd0, if_instr}, {16'd0, mem(16'h0040)});

        // Redirect in the same cycle as the ack of address 3.
        ack_delay = 0;
        quiet_redirect(16'h0003);
        check("req_at_3", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0003});
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("req_at_100", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0100});
`ifdef IF_PERF_EN
        check("perf_two", {16'd0, perf_discard_cnt}, 32'd2);
`endif
        wait_valid_pc("target_100", 16'h0100);

        // PC wrap at 16'hFFFF.
        quiet_redirect(16'hFFFF);
        stall = 1'b0;
        tick();
        check("wrap_pc", {15'd0, if_valid, if_pc}, {15'd0, 1'b1, 16'hFFFF});
        check("wrap_plus1", {16'd0, if_pc_plus1}, 32'd0);
        check("wrap_addr", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});

        // Reset in the middle of an outstanding request.
        ack_delay = 3;
        wait_req_addr("req_before_reset", 16'h0000);
        reset_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_valid", {31'd0, if_valid}, 32'd0);
`ifdef IF_PERF_EN
        check("async_rst_perf", {16'd0, perf_discard_cnt}, 32'd0);
`endif
        tick();
        tick();
        reset_n   = 1'b1;
        ack_delay = 1;
        wait_valid_pc("refetch_0", 16'h0000);
        check("refetch_instr", {16'd0, if_instr}, 32'h2401);
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
